// File: rtl/nibble_cascade_cmp_ctrl.sv
// nibble_cascade_cmp_ctrl: MSB-first nibble-serial unsigned magnitude compare with start/done handshake
module nibble_cascade_cmp_ctrl #(
  parameter int WIDTH = 16,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int N = WIDTH / 4,
  localparam int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_ls_b,
  output logic             a_gt_b,
  output logic [IW-1:0]    nib_idx
);
  localparam logic [IW-1:0] TOP = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0] idx;
  logic decided, pend_gt;
  logic [3:0] na, nb;
  logic neq, ngt, last;
  always_comb begin
    na = ra[4*idx +: 4];
    nb = rb[4*idx +: 4];
    neq = na != nb;
    ngt = na > nb;
    last = (idx == '0) || (EARLY_EXIT && neq);
    state_d = state == IDLE ? (start ? CMP : IDLE) :
              state == CMP  ? (last ? DONE : CMP) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    nib_idx = state == CMP ? idx : TOP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      idx <= TOP;
      decided <= 1'b0;
      pend_gt <= 1'b0;
      a_eq_b <= 1'b0;
      a_ls_b <= 1'b0;
      a_gt_b <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        ra <= a;
        rb <= b;
        idx <= TOP;
        decided <= 1'b0;
        pend_gt <= 1'b0;
      end
      if (state == CMP) begin
        if (neq && !decided) begin
          decided <= 1'b1;
          pend_gt <= ngt;
        end
        // the first unequal nibble (most significant) owns the result
        if (last) begin
          a_eq_b <= !(decided || neq);
          a_gt_b <= decided ? pend_gt : (neq && ngt);
          a_ls_b <= decided ? !pend_gt : (neq && !ngt);
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_cascade_cmp_ctrl.sv
// tb_nibble_cascade_cmp_ctrl: directed checks of early-exit and fixed-latency compare controllers side by side
module tb_nibble_cascade_cmp_ctrl;
  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] a, b;
  logic busy1, done1, eq1, ls1, gt1;
  logic busy0, done0, eq0, ls0, gt0;
  logic [1:0] nib1, nib0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_cascade_cmp_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy1), .done(done1),
    .a_eq_b(eq1), .a_ls_b(ls1), .a_gt_b(gt1), .nib_idx(nib1));
  nibble_cascade_cmp_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy0), .done(done0),
    .a_eq_b(eq0), .a_ls_b(ls0), .a_gt_b(gt0), .nib_idx(nib0));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic e1, l1, g1, e0, l0, g0);
    chk({tag, " busy1"}, busy1, 0);
    chk({tag, " done1"}, done1, 0);
    chk({tag, " flags1"}, {eq1, ls1, gt1}, {e1, l1, g1});
    chk({tag, " nib1"}, nib1, 3);
    chk({tag, " busy0"}, busy0, 0);
    chk({tag, " done0"}, done0, 0);
    chk({tag, " flags0"}, {eq0, ls0, gt0}, {e0, l0, g0});
    chk({tag, " nib0"}, nib0, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_idle("reset_idle", 0, 0, 0, 0, 0, 0);
      tick;
    end

    // equal operands: both variants scan all four nibbles
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("eq busy1", busy1, 1);
      chk("eq done1", done1, 0);
      chk("eq nib1", nib1, 3 - i);
      chk("eq nib0", nib0, 3 - i);
      tick;
    end
    chk("eq done1", done1, 1);
    chk("eq busy1 in done", busy1, 1);
    chk("eq flags1", {eq1, ls1, gt1}, 3'b100);
    chk("eq done0", done0, 1);
    chk("eq flags0", {eq0, ls0, gt0}, 3'b100);
    tick;
    chk_idle("eq after", 1, 0, 0, 1, 0, 0);

    // MSB nibble differs: early exit after one CMP cycle
    a = 16'h5000; b = 16'h4FFF; start = 1'b1;
    tick;
    start = 1'b0;
    chk("gt cmp done1", done1, 0);
    chk("gt cmp nib1", nib1, 3);
    tick;
    chk("gt done1", done1, 1);
    chk("gt flags1", {eq1, ls1, gt1}, 3'b001);
    chk("gt nib0", nib0, 2);
    chk("gt done0 early", done0, 0);
    tick;
    chk("gt busy1 after", busy1, 0);
    chk("gt flags1 hold", {eq1, ls1, gt1}, 3'b001);
    tick; tick;
    chk("gt done0", done0, 1);
    chk("gt flags0", {eq0, ls0, gt0}, 3'b001);
    tick;
    chk_idle("gt after", 0, 0, 1, 0, 0, 1);

    // less-significant F>0 must not override the decided ls
    a = 16'h12F0; b = 16'h1300; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("ls nib1", nib1, 2);
    tick;
    chk("ls done1", done1, 1);
    chk("ls flags1", {eq1, ls1, gt1}, 3'b010);
    chk("ls done0 early", done0, 0);
    chk("ls nib0", nib0, 1);
    tick;
    chk("ls done0 early2", done0, 0);
    tick;
    chk("ls done0", done0, 1);
    chk("ls flags0", {eq0, ls0, gt0}, 3'b010);
    tick;
    chk_idle("ls after", 0, 1, 0, 0, 1, 0);

    // start held and operands changed mid-compare
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    tick;
    a = 16'hFFFF; b = 16'h0000;
    tick; tick; tick;
    chk("hold nib1", nib1, 0);
    tick;
    chk("hold done1", done1, 1);
    chk("hold flags1", {eq1, ls1, gt1}, 3'b010);
    chk("hold done0", done0, 1);
    chk("hold flags0", {eq0, ls0, gt0}, 3'b010);
    tick;
    chk("hold idle busy1", busy1, 0);
    chk("hold idle busy0", busy0, 0);
    tick;
    start = 1'b0;
    chk("reaccept busy1", busy1, 1);
    chk("reaccept nib1", nib1, 3);
    tick;
    chk("re done1", done1, 1);
    chk("re flags1", {eq1, ls1, gt1}, 3'b001);
    tick; tick; tick;
    chk("re done0", done0, 1);
    chk("re flags0", {eq0, ls0, gt0}, 3'b001);
    tick;

    // reset during the 2nd CMP cycle
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("rst pre nib1", nib1, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_idle("rst mid", 0, 0, 0, 0, 0, 0);
      tick;
    end
    a = 16'h0300; b = 16'h0200; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("post done1 early", done1, 0);
    tick;
    chk("post done1", done1, 1);
    chk("post flags1", {eq1, ls1, gt1}, 3'b001);
    tick; tick;
    chk("post done0", done0, 1);
    chk("post flags0", {eq0, ls0, gt0}, 3'b001);
    tick;
    chk_idle("post after", 0, 0, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
